spgd_update_core: RTL and testbench

Datapath stage directly downstream of the SPGD sequencer. It integrates ADC samples during the sequencer's ADC windows and latches the J+ and J− metrics on the write strobes. On the U-write strobe it updates the control value U by the signed, gain-scaled metric difference. It also drives the 14-bit DAC word selected by the sequencer's DAC_SEL code: off, U+δ, U−δ or U.

---
 rtl/spgd_update_core.sv | 128 ++++++++++++
 tb/tb_spgd_update_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spgd_update_core.sv
// SPGD datapath: integrates ADC samples, latches J+/J-, applies the gain-scaled U update
// and drives the selected DAC word. Define SPGD_LFSR_PERT_EN to enable the LFSR perturbation sign.
module spgd_update_core #(
    parameter int unsigned        ACC_W  = 32,
    parameter logic signed [13:0] U_INIT = 14'sd0
) (
    input  logic             adc_clk,
    input  logic             adc_rstn,
    input  logic [13:0]      adc_dat,
    input  logic             FSM_ADC_COUNTER_START,
    input  logic             FSM_ADC_COUNTER_RST,
    input  logic             FSM_JP_WRT,
    input  logic             FSM_JM_WRT,
    input  logic             FSM_U_WRT,
    input  logic             FSM_REG_RST,
    input  logic [1:0]       FSM_DAC_SEL,
    input  logic [4:0]       gain_shift,
    input  logic [12:0]      pert_amp,
    output logic [13:0]      dac_dat,
    output logic [13:0]      u_out,
    output logic [ACC_W-1:0] j_plus,
    output logic [ACC_W-1:0] j_minus,
    output logic             pert_sign
);

    localparam int unsigned DW = 14;
    localparam int unsigned SW = ACC_W + 2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [SW-1:0]    S14_MAX = SW'(8191);
    localparam logic signed [SW-1:0]    S14_MIN = SW'(-8192);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] jp_q;
    logic signed [ACC_W-1:0] jm_q;
    logic signed [DW-1:0]    u_q;
    logic        [DW-1:0]    dac_q;
    logic                    s_neg;

    logic signed [ACC_W:0]   acc_sum_c;
    logic signed [ACC_W-1:0] acc_sat_c;
    logic signed [ACC_W:0]   diff_c;
    logic signed [ACC_W:0]   step_c;
    logic signed [SW-1:0]    u_ext_c;
    logic signed [SW-1:0]    u_sum_c;
    logic signed [SW-1:0]    amp_ext_c;
    logic        [DW-1:0]    dac_nxt_c;

    // Clamp a wide signed value into the 14-bit DAC/U range.
    function automatic logic signed [DW-1:0] sat14(input logic signed [SW-1:0] v);
        if (v > S14_MAX)      return 14'sh1FFF;
        else if (v < S14_MIN) return 14'sh2000;
        else                  return v[DW-1:0];
    endfunction

    // Saturating accumulate: overflow shows as disagreement of the two top sum bits.
    always_comb begin
        acc_sum_c = (ACC_W+1)'(acc_q) + (ACC_W+1)'($signed(adc_dat));
        acc_sat_c = acc_sum_c[ACC_W-1:0];
        if (acc_sum_c[ACC_W] != acc_sum_c[ACC_W-1])
            acc_sat_c = acc_sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
    end

    always_comb begin
        diff_c    = (ACC_W+1)'(jp_q) - (ACC_W+1)'(jm_q);
        step_c    = diff_c >>> gain_shift;
        u_ext_c   = SW'(u_q);
        u_sum_c   = s_neg ? (u_ext_c - SW'(step_c)) : (u_ext_c + SW'(step_c));
        amp_ext_c = SW'($signed({1'b0, pert_amp}));
    end

    // DAC source select; 01/10 swap roles when the perturbation sign is negative.
    always_comb begin
        dac_nxt_c = '0;
        case (FSM_DAC_SEL)
            2'b01:   dac_nxt_c = s_neg ? sat14(u_ext_c - amp_ext_c) : sat14(u_ext_c + amp_ext_c);
            2'b10:   dac_nxt_c = s_neg ? sat14(u_ext_c + amp_ext_c) : sat14(u_ext_c - amp_ext_c);
            2'b11:   dac_nxt_c = u_q;
            default: dac_nxt_c = '0;
        endcase
    end

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            acc_q <= '0;
            jp_q  <= '0;
            jm_q  <= '0;
            u_q   <= U_INIT;
            dac_q <= '0;
        end else begin
            if (FSM_REG_RST) begin
                acc_q <= '0;
                jp_q  <= '0;
                jm_q  <= '0;
                u_q   <= U_INIT;
            end else begin
                if (FSM_ADC_COUNTER_RST)        acc_q <= '0;
                else if (FSM_ADC_COUNTER_START) acc_q <= acc_sat_c;
                if (FSM_JP_WRT) jp_q <= acc_q;
                if (FSM_JM_WRT) jm_q <= acc_q;
                if (FSM_U_WRT)  u_q  <= sat14(u_sum_c);
            end
            dac_q <= dac_nxt_c;
        end
    end

`ifdef SPGD_LFSR_PERT_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward bit 0; advances once per update.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn)      lfsr_q <= 16'hACE1;
        else if (FSM_U_WRT) lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign s_neg = lfsr_q[0];
`else
    assign s_neg = 1'b0;
`endif

    assign dac_dat   = dac_q;
    assign u_out     = u_q;
    assign j_plus    = jp_q;
    assign j_minus   = jm_q;
    assign pert_sign = s_neg;

endmodule

// File: tb/tb_spgd_update_core.sv
// Self-checking bench for spgd_update_core: directed sequences, a DAC mux table and
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_spgd_update_core;

    localparam int ACC_W = 20;
    localparam logic signed [13:0] U_INIT = 14'sd0;

    logic              adc_clk = 1'b0;
    logic              adc_rstn;
    logic [13:0]       adc_dat;
    logic              cnt_start, cnt_rst, jp_wrt, jm_wrt, u_wrt, reg_rst;
    logic [1:0]        dac_sel;
    logic [4:0]        gain_shift;
    logic [12:0]       pert_amp;
    logic [13:0]       dac_dat, u_out;
    logic [ACC_W-1:0]  j_plus, j_minus;
    logic              pert_sign;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    longint     m_acc, m_jp, m_jm, m_u, m_dac;
    logic [15:0] m_lfsr;

    always #5 adc_clk = ~adc_clk;

    spgd_update_core #(.ACC_W(ACC_W), .U_INIT(U_INIT)) dut (
        .adc_clk(adc_clk), .adc_rstn(adc_rstn), .adc_dat(adc_dat),
        .FSM_ADC_COUNTER_START(cnt_start), .FSM_ADC_COUNTER_RST(cnt_rst),
        .FSM_JP_WRT(jp_wrt), .FSM_JM_WRT(jm_wrt), .FSM_U_WRT(u_wrt),
        .FSM_REG_RST(reg_rst), .FSM_DAC_SEL(dac_sel), .gain_shift(gain_shift),
        .pert_amp(pert_amp), .dac_dat(dac_dat), .u_out(u_out),
        .j_plus(j_plus), .j_minus(j_minus), .pert_sign(pert_sign)
    );

    function automatic longint clampw(longint v, int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint m_sneg();
`ifdef SPGD_LFSR_PERT_EN
        return longint'(m_lfsr[0]);
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_acc = 0; m_jp = 0; m_jm = 0; m_u = U_INIT; m_dac = 0; m_lfsr = 16'hACE1;
    endtask

    // One clock edge of the specified behaviour, evaluated from pre-edge state.
    task automatic model_step();
        longint sgn, amp, n_acc, n_jp, n_jm, n_u, d, st;
        sgn = (m_sneg() != 0) ? -1 : 1;
        amp = longint'(pert_amp);
        case (dac_sel)
            2'd1:    m_dac = clampw(m_u + sgn * amp, 14);
            2'd2:    m_dac = clampw(m_u - sgn * amp, 14);
            2'd3:    m_dac = m_u;
            default: m_dac = 0;
        endcase
        n_acc = m_acc; n_jp = m_jp; n_jm = m_jm; n_u = m_u;
        if (reg_rst) begin
            n_acc = 0; n_jp = 0; n_jm = 0; n_u = U_INIT;
        end else begin
            if (cnt_rst)        n_acc = 0;
            else if (cnt_start) n_acc = clampw(m_acc + longint'($signed(adc_dat)), ACC_W);
            if (jp_wrt) n_jp = m_acc;
            if (jm_wrt) n_jm = m_acc;
            if (u_wrt) begin
                d   = m_jp - m_jm;
                st  = d >>> gain_shift;
                n_u = clampw(m_u + sgn * st, 14);
            end
        end
        if (u_wrt) m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        m_acc = n_acc; m_jp = n_jp; m_jm = n_jm; m_u = n_u;
    endtask

    task automatic chk(input string name, input logic signed [63:0] act, input longint exp);
        logic signed [63:0] e;
        e = exp;
        n_total++;
        if (act !== e) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, e, $time);
        else n_pass++;
    endtask

    task automatic check_all();
        chk("dac_dat", $signed(dac_dat), m_dac);
        chk("u_out", $signed(u_out), m_u);
        chk("j_plus", $signed(j_plus), m_jp);
        chk("j_minus", $signed(j_minus), m_jm);
        chk("pert_sign", pert_sign, m_sneg());
    endtask

    task automatic cyc();
        @(posedge adc_clk);
        if (adc_rstn) model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        cnt_start = 0; cnt_rst = 0; jp_wrt = 0; jm_wrt = 0; u_wrt = 0; reg_rst = 0;
    endtask

    task automatic accumulate(input int val, input int n);
        idle(); cnt_rst = 1; cyc();
        idle(); cnt_start = 1; adc_dat = 14'(val);
        repeat (n) cyc();
        idle();
    endtask

    task automatic randomize_inputs();
        int mode;
        mode       = $urandom_range(0, 3);
        adc_dat    = (mode == 0) ? 14'h1FFF : (mode == 1) ? 14'h2000 : 14'($urandom);
        cnt_start  = ($urandom_range(0, 9) < 8);
        cnt_rst    = ($urandom_range(0, 19) == 0);
        jp_wrt     = ($urandom_range(0, 9) == 0);
        jm_wrt     = ($urandom_range(0, 9) == 0);
        u_wrt      = ($urandom_range(0, 9) == 0);
        reg_rst    = ($urandom_range(0, 99) == 0);
        dac_sel    = 2'($urandom);
        gain_shift = 5'($urandom_range(0, 12));
        pert_amp   = 13'($urandom);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [12:0] amp;
        int          exp_dac;
    } dac_vec_t;

    initial begin
        dac_vec_t tbl[8];
        tbl[0] = '{2'b01, 13'd50,   1050};
        tbl[1] = '{2'b10, 13'd50,   950};
        tbl[2] = '{2'b11, 13'd50,   1000};
        tbl[3] = '{2'b00, 13'd50,   0};
        tbl[4] = '{2'b01, 13'd8191, 8191};
        tbl[5] = '{2'b10, 13'd8191, -7191};
        tbl[6] = '{2'b01, 13'd7191, 8191};
        tbl[7] = '{2'b10, 13'd0,    1000};

        // Reset held with inputs toggling
        adc_rstn = 0;
        model_reset();
        repeat (4) begin
            randomize_inputs();
            @(posedge adc_clk); #1;
            check_all();
        end
        chk("rst_u", $signed(u_out), U_INIT);
`ifdef SPGD_LFSR_PERT_EN
        chk("rst_sign", pert_sign, 1);
`else
        chk("rst_sign", pert_sign, 0);
`endif
        adc_rstn = 1;
        idle(); adc_dat = 0; dac_sel = 2'b11; gain_shift = 0; pert_amp = 0;
        cyc();

        // Accumulate and capture, capture coinciding with the clear
        accumulate(100, 4);
        jp_wrt = 1; cnt_rst = 1; cyc();
        chk("jp_400", $signed(j_plus), 400);
        idle(); jm_wrt = 1; cyc();
        chk("acc_cleared", $signed(j_minus), 0);
        accumulate(-25, 4);
        jm_wrt = 1; cnt_rst = 1; cyc();
        chk("jm_neg100", $signed(j_minus), -100);

        // Accumulator saturation in both directions
        accumulate(8191, 70);
        jp_wrt = 1; cnt_rst = 1; cyc();
        chk("acc_sat_pos", $signed(j_plus), (1 <<< (ACC_W - 1)) - 1);
        accumulate(-8192, 70);
        jp_wrt = 1; cnt_rst = 1; cyc();
        chk("acc_sat_neg", $signed(j_plus), -(1 <<< (ACC_W - 1)));

`ifndef SPGD_LFSR_PERT_EN
        // Update: (400-100)>>>2 = 75, u_out after 1 cycle, dac after 2
        idle(); reg_rst = 1; cyc();
        accumulate(100, 4); jp_wrt = 1; cnt_rst = 1; cyc();
        accumulate(25, 4);  jm_wrt = 1; cnt_rst = 1; cyc();
        idle(); dac_sel = 2'b11; gain_shift = 2; cyc();
        u_wrt = 1; cyc();
        chk("u_75", $signed(u_out), 75);
        chk("dac_lat1", $signed(dac_dat), 0);
        idle(); cyc();
        chk("dac_lat2", $signed(dac_dat), 75);

        // U saturation at +8191 then DAC saturation
        reg_rst = 1; cyc();
        accumulate(100, 81); jp_wrt = 1; cnt_rst = 1; cyc();
        idle(); gain_shift = 0; u_wrt = 1; cyc();
        chk("u_8100", $signed(u_out), 8100);
        accumulate(100, 2); jp_wrt = 1; cnt_rst = 1; cyc();
        idle(); u_wrt = 1; cyc();
        chk("u_sat", $signed(u_out), 8191);
        idle(); dac_sel = 2'b01; pert_amp = 500; cyc();
        chk("dac_sat", $signed(dac_dat), 8191);
        dac_sel = 2'b10; cyc();
        chk("dac_minus", $signed(dac_dat), 7691);

        // DAC mux table with U = 1000
        reg_rst = 1; cyc();
        accumulate(250, 4); jp_wrt = 1; cnt_rst = 1; cyc();
        idle(); gain_shift = 0; u_wrt = 1; cyc();
        idle();
        for (int i = 0; i < 8; i++) begin
            dac_sel = tbl[i].sel; pert_amp = tbl[i].amp;
            cyc();
            chk($sformatf("dac_tbl%0d", i), $signed(dac_dat), tbl[i].exp_dac);
        end

        // 100 held U_WRT cycles: sign stays +1, each adds +3
        reg_rst = 1; cyc();
        accumulate(3, 1); jp_wrt = 1; cnt_rst = 1; cyc();
        idle(); gain_shift = 0; u_wrt = 1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            chk("u_ramp", $signed(u_out), 3 * (i + 1));
        end
        idle();
`endif

        // Asynchronous reset mid-sequence, then normal operation resumes
        accumulate(77, 3);
        cnt_start = 1; jp_wrt = 1; u_wrt = 1; dac_sel = 2'b11;
        #3 adc_rstn = 0;
        model_reset();
        #1 check_all();
        @(negedge adc_clk);
        adc_rstn = 1;
        idle(); jp_wrt = 1; cyc();
        chk("post_rst_jp", $signed(j_plus), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            randomize_inputs();
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
